// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the execute stage and the
// sequential divider. The pipeline side is the master, the divider the slave.
interface seq_divider_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              signed_mode;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              flush;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_zero;
  logic              ready;
  logic              busy;
  logic              stall;

  modport master (
    output start, signed_mode, a, b, flush,
    input  quotient, remainder, div_zero, ready, busy, stall
  );

  modport slave (
    input  start, signed_mode, a, b, flush,
    output quotient, remainder, div_zero, ready, busy, stall
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for the execute stage.
// Works on magnitudes, applies sign correction in a final cycle, and
// reports divide-by-zero without entering the iteration loop.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, MSB first
// FIX   | sign correction, results written
// DONE  | ready pulse; start here issues back-to-back
module seq_divider #(
  parameter int DATA_W    = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  seq_divider_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_bmag;
  logic [DATA_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_remd;
  logic              r_dz;

  logic              w_can_issue;
  logic              w_accept;
  logic              w_sgn;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_b_zero;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;

  assign w_can_issue = (r_state == S_IDLE) || (r_state == S_DONE);
  // flush beats start: an issue in the same cycle as a flush is dropped
  assign w_accept    = w_can_issue && bus.start && !bus.flush;

  assign w_sgn    = (SIGNED_EN != 1'b0) && bus.signed_mode;
  assign w_a_neg  = w_sgn && bus.a[DATA_W-1];
  assign w_b_neg  = w_sgn && bus.b[DATA_W-1];
  // DATA_W-bit absolute value: MIN maps onto itself, which is the correct
  // unsigned magnitude 2^(DATA_W-1)
  assign w_a_mag  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
  assign w_b_zero = (bus.b == '0);

  // The shifted partial remainder needs one extra bit; the stored remainder
  // is always below the divisor magnitude and fits in DATA_W bits.
  assign w_shift = {r_rem, r_dvd[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_bmag};
  // shifted value < 2*divisor, so the difference MSB is exactly the borrow
  assign w_ge    = !w_diff[DATA_W];

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            w_next = w_b_zero ? S_DONE : S_CALC;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_CALC: begin
          if (r_cnt == '0) begin
            w_next = S_FIX;
          end
        end
        S_FIX: begin
          w_next = S_DONE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // handshake outputs and held results
  always_comb begin
    bus.ready     = (r_state == S_DONE);
    bus.busy      = (r_state == S_CALC) || (r_state == S_FIX);
    bus.stall     = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
    bus.quotient  = r_quot;
    bus.remainder = r_remd;
    bus.div_zero  = r_dz;
  end

  // operand load, restoring iteration and result write-back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dvd   <= '0;
      r_bmag  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_dvd   <= w_a_mag;
      r_bmag  <= w_b_mag;
      r_rem   <= '0;
      r_cnt   <= CNT_INIT;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_b_zero) begin
        r_quot <= '1;
        r_remd <= bus.a;
        r_dz   <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
      // dividend bits shift out the top while quotient bits enter the bottom
      r_dvd <= {r_dvd[DATA_W-2:0], w_ge};
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if ((r_state == S_FIX) && !bus.flush) begin
      r_quot <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
      r_remd <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
      r_dz   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: fixed vectors, random operands
// against an arithmetic reference, and hand-built flush/reset/issue sequences.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int W  = 16;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_if #(.DATA_W(W))  dif ();
  seq_divider_if #(.DATA_W(W8)) dif8 ();

  seq_divider #(.DATA_W(W), .SIGNED_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(dif)
  );
  seq_divider #(.DATA_W(W8), .SIGNED_EN(1'b0)) dut8 (
    .i_clk(clk), .i_rst(rst), .bus(dif8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] prev_q, prev_r;
  bit          prev_z;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sm;
    logic [15:0] q;
    logic [15:0] r;
    bit          dz;
  } vec_t;

  vec_t vecs[12];

  logic [15:0] ra, rb, eq, er;
  bit          rs, ez;
  int          sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero, plus the
  // documented divide-by-zero result.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input bit sm, output logic [15:0] q, output logic [15:0] r,
                                output bit dz);
    longint full = longint'(1) << w;
    longint mask = full - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa, sb, lq, lr;
    dz = (ub == 0);
    if (dz) begin
      lq = mask;
      lr = ua;
    end else if (!sm) begin
      lq = ua / ub;
      lr = ua % ub;
    end else begin
      sa = (ua >= full / 2) ? ua - full : ua;
      sb = (ub >= full / 2) ? ub - full : ub;
      lq = sa / sb;
      lr = sa % sb;
    end
    q = 16'(lq & mask);
    r = 16'(lr & mask);
  endfunction

  // Issue one divide on the 16-bit unit and wait for ready. ready is expected
  // right after edge W+1 (nonzero divisor) or edge 0 (zero divisor), counting
  // the edge that samples start as edge 0. With hold set, start stays high
  // with different operands until ready and must be ignored.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input bit sm, input bit hold, input logic [15:0] q_exp,
                         input logic [15:0] r_exp, input bit z_exp);
    int idx = 0;
    bit seen;
    bit ok = 1'b1;
    dif.a = a; dif.b = b; dif.signed_mode = sm; dif.start = 1'b1; dif.flush = 1'b0;
    #1;
    check({tag, "/stall_issue"}, 32'(dif.stall), 32'd1);
    tick();
    if (hold) begin
      dif.a = ~a; dif.b = 16'd3; dif.signed_mode = ~sm;
    end else begin
      dif.start = 1'b0;
    end
    #1;
    seen = dif.ready;
    while (!seen && idx < 40) begin
      if (dif.stall !== 1'b1 || dif.busy !== 1'b1) ok = 1'b0;
      tick();
      idx++;
      #1;
      seen = dif.ready;
    end
    if (hold) begin
      dif.start = 1'b0;
      #1;
    end
    check({tag, "/ready_edge"}, 32'(idx), (b == 16'd0) ? 32'd0 : 32'(W + 1));
    check({tag, "/stall_done"}, 32'(dif.stall), 32'd0);
    if (b != 16'd0) check({tag, "/stall_busy_calc"}, 32'(ok), 32'd1);
    check({tag, "/quotient"}, 32'(dif.quotient), 32'(q_exp));
    check({tag, "/remainder"}, 32'(dif.remainder), 32'(r_exp));
    check({tag, "/div_zero"}, 32'(dif.div_zero), 32'(z_exp));
    prev_q = q_exp; prev_r = r_exp; prev_z = z_exp;
  endtask

  task automatic run_div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input bit sm, input logic [7:0] q_exp, input logic [7:0] r_exp,
                          input bit z_exp);
    int idx = 0;
    bit seen;
    dif8.a = a; dif8.b = b; dif8.signed_mode = sm; dif8.start = 1'b1;
    #1;
    check({tag, "/stall_issue"}, 32'(dif8.stall), 32'd1);
    tick();
    dif8.start = 1'b0;
    #1;
    seen = dif8.ready;
    while (!seen && idx < 30) begin
      tick();
      idx++;
      #1;
      seen = dif8.ready;
    end
    check({tag, "/ready_edge"}, 32'(idx), (b == 8'd0) ? 32'd0 : 32'(W8 + 1));
    check({tag, "/quotient"}, 32'(dif8.quotient), 32'(q_exp));
    check({tag, "/remainder"}, 32'(dif8.remainder), 32'(r_exp));
    check({tag, "/div_zero"}, 32'(dif8.div_zero), 32'(z_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw_ready;

    vecs[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0};
    vecs[1]  = '{16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[2]  = '{16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0};
    vecs[3]  = '{16'h1234, 16'd0,    1'b0, 16'hFFFF, 16'h1234, 1'b1};
    vecs[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'd0,    1'b0};
    vecs[5]  = '{16'h8000, 16'hFFFF, 1'b0, 16'd0,    16'h8000, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'd0,    1'b0};
    vecs[7]  = '{16'h9000, 16'd0,    1'b1, 16'hFFFF, 16'h9000, 1'b1};
    vecs[8]  = '{16'hFF9C, 16'hFFF9, 1'b1, 16'd14,   16'hFFFE, 1'b0};
    vecs[9]  = '{16'd0,    16'd5,    1'b1, 16'd0,    16'd0,    1'b0};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'd1,    16'd0,    1'b0};
    vecs[11] = '{16'd5,    16'd7,    1'b1, 16'd0,    16'd5,    1'b0};

    rst = 1'b1;
    dif.start = 1'b0; dif.signed_mode = 1'b0; dif.a = '0; dif.b = '0; dif.flush = 1'b0;
    dif8.start = 1'b0; dif8.signed_mode = 1'b0; dif8.a = '0; dif8.b = '0; dif8.flush = 1'b0;
    repeat (3) tick();
    check("reset/quotient", 32'(dif.quotient), 32'd0);
    check("reset/remainder", 32'(dif.remainder), 32'd0);
    check("reset/div_zero", 32'(dif.div_zero), 32'd0);
    check("reset/ready", 32'(dif.ready), 32'd0);
    check("reset/busy", 32'(dif.busy), 32'd0);
    check("reset/stall", 32'(dif.stall), 32'd0);
    check("reset8/quotient", 32'(dif8.quotient), 32'd0);
    rst = 1'b0;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    tick();

    // Fixed vectors, issued back-to-back from the DONE cycle
    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0,
              vecs[i].q, vecs[i].r, vecs[i].dz);
    end
    tick();

    // start held high with new operands through CALC/FIX must not disturb
    // the result nor queue a second divide
    run_div("hold", 16'd100, 16'd7, 1'b0, 1'b1, 16'd14, 16'd2, 1'b0);
    tick();
    check("hold/no_queue_busy", 32'(dif.busy), 32'd0);
    check("hold/no_queue_ready", 32'(dif.ready), 32'd0);

    // back-to-back issue from DONE: second result after the full latency
    run_div("b2b_first", 16'd1000, 16'd3, 1'b0, 1'b0, 16'd333, 16'd1, 1'b0);
    run_div("b2b_second", 16'd9, 16'd4, 1'b0, 1'b0, 16'd2, 16'd1, 1'b0);
    tick();

    // flush at edge 5 of 1000/3
    dif.a = 16'd1000; dif.b = 16'd3; dif.signed_mode = 1'b0; dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (4) tick();
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    tick();
    check("flush/busy", 32'(dif.busy), 32'd0);
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dif.ready) saw_ready = 1'b1;
      tick();
    end
    check("flush/no_ready", 32'(saw_ready), 32'd0);
    check("flush/q_held", 32'(dif.quotient), 32'(prev_q));
    check("flush/r_held", 32'(dif.remainder), 32'(prev_r));
    check("flush/z_held", 32'(dif.div_zero), 32'(prev_z));
    run_div("after_flush", 16'd9, 16'd4, 1'b0, 1'b0, 16'd2, 16'd1, 1'b0);
    tick();

    // start together with flush is not accepted
    dif.a = 16'd50; dif.b = 16'd0; dif.start = 1'b1; dif.flush = 1'b1;
    #1;
    check("start_flush/stall", 32'(dif.stall), 32'd0);
    tick();
    dif.start = 1'b0; dif.flush = 1'b0;
    #1;
    check("start_flush/ready", 32'(dif.ready), 32'd0);
    check("start_flush/busy", 32'(dif.busy), 32'd0);
    check("start_flush/q_held", 32'(dif.quotient), 32'(prev_q));
    check("start_flush/z_held", 32'(dif.div_zero), 32'(prev_z));
    tick();

    // Random operands against the arithmetic reference
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (sel == 0) rb = 16'd0;
      else if (sel == 1) rb = 16'($urandom_range(1, 15));
      else if (sel == 2) begin ra = 16'h8000; rb = 16'hFFFF; end
      model(W, ra, rb, rs, eq, er, ez);
      run_div($sformatf("rand%0d", i), ra, rb, rs, 1'b0, eq, er, ez);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();

    // reset in the middle of CALC clears everything
    dif.a = 16'd100; dif.b = 16'd7; dif.signed_mode = 1'b0; dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid/quotient", 32'(dif.quotient), 32'd0);
    check("rst_mid/remainder", 32'(dif.remainder), 32'd0);
    check("rst_mid/div_zero", 32'(dif.div_zero), 32'd0);
    check("rst_mid/ready", 32'(dif.ready), 32'd0);
    check("rst_mid/busy", 32'(dif.busy), 32'd0);
    check("rst_mid/stall", 32'(dif.stall), 32'd0);
    tick();

    // 8-bit unsigned-only variant: signed_mode must be ignored
    run_div8("w8_200_9", 8'd200, 8'd9, 1'b1, 8'd22, 8'd2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      rs = 1'($urandom_range(0, 1));
      model(W8, ra, rb, 1'b0, eq, er, ez);
      run_div8($sformatf("w8_rand%0d", i), ra[7:0], rb[7:0], rs, eq[7:0], er[7:0], ez);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle radix-2 divider that generates the quotient and remainder the execute stage consumes, together with the ready and stall handshake toward the pipeline control. It generalises the fixed 16-bit divide path to any data width and adds the following:

- signed and unsigned modes
- divide-by-zero reporting
- pipeline flush (abort)
- back-to-back issue

It sits inside the execute stage. Its `stall` output is ORed into the global pipeline stall.

## Interface
Parameters:
- `DATA_W`, default 16: operand and result width. Must be ≥ 2.
- `SIGNED_EN`, default 1: when 0, `signed_mode` is ignored and all divides are unsigned.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: issue a divide. Sampled only in IDLE or DONE.
- `signed_mode` in 1: 1 = two's-complement operands. Sampled with `start`.
- `a` in DATA_W: dividend. Sampled with `start`.
- `b` in DATA_W: divisor. Sampled with `start`.
- `flush` in 1: abort any operation in flight.
- `quotient` out DATA_W: result, registered.
- `remainder` out DATA_W: result, registered.
- `div_zero` out 1: the last result came from a zero divisor.
- `ready` out 1: one-cycle pulse, results valid.
- `busy` out 1: high in CALC or FIX.
- `stall` out 1: combinational. `start` accepted this cycle OR state is CALC OR state is FIX.

## Operation
States:
- **IDLE**
  - `start` → latch operands.
  - `b == 0` → DONE.
  - Otherwise → CALC, with count = DATA_W−1.
- **CALC**
  - One restoring step per cycle: shift the partial remainder left by one, bringing in the next dividend magnitude bit, MSB first.
  - If partial remainder ≥ divisor magnitude, subtract and set the quotient bit.
  - When count reaches 0 → FIX. Otherwise decrement count.
- **FIX**
  - Sign correction, then → DONE.
  - Quotient is negated when the signs of `a` and `b` differ (signed mode).
  - Remainder is negated when `a` is negative, so it takes the sign of the dividend (truncating division).
- **DONE**
  - `ready` = 1 for exactly this cycle.
  - `start` → behaves as in IDLE (back-to-back issue).
  - Otherwise → IDLE.

Arithmetic:
- Operands are converted to magnitude at load using a DATA_W-bit absolute value.
- Partial remainder is DATA_W+1 bits.

Boundary results:
- Divide by zero: `quotient` = all ones, `remainder` = `a`, `div_zero` = 1. This holds in both modes.
- Signed MIN / −1: `quotient` = MIN (wraps), `remainder` = 0, `div_zero` = 0.

Output holding:
- `quotient`, `remainder` and `div_zero` hold their values until the next result is written in FIX or at the DONE entry.

Ignored and overriding inputs:
- `start` in CALC or FIX is ignored and does not queue.
- `flush` in any state → IDLE on the next edge. No `ready` is produced and held results are unchanged.
- `flush` together with `start` in the same cycle: `flush` wins, the operation is not accepted, and `stall` = 0.

## Timing
- Reset (`rst` high at an edge):
  - State → IDLE.
  - `quotient`, `remainder`, `div_zero`, `ready`, `busy` = 0.
  - `stall` = 0 unless `start` is high.
  - `rst` overrides `flush` and `start`.
- Edge 0 is the edge that samples `start`.
- Nonzero divisor:
  - CALC occupies edges 1..DATA_W.
  - FIX is evaluated at edge DATA_W+1.
  - `ready` is high in the cycle after edge DATA_W+1.
  - Issue-to-ready latency is DATA_W+1 edges; 17 for DATA_W = 16.
- Zero divisor: `ready` is high in the cycle after edge 0, i.e. a latency of 1.
- `stall` is low in the DONE cycle, so the pipeline advances and captures the result while `ready` is high.
- Maximum throughput: one divide per DATA_W+2 cycles, using back-to-back `start` in DONE.

## Test plan
- **Unsigned.** DATA_W = 16, `a` = 100, `b` = 7, `signed_mode` = 0.
  - Required: `ready` exactly 17 edges after issue, `quotient` = 14, `remainder` = 2.
  - `stall` high from the issue cycle through the FIX cycle and low in the DONE cycle.
- **Signed.** `a` = 0xFFF9 (−7), `b` = 2, `signed_mode` = 1.
  - Required: `quotient` = 0xFFFD, `remainder` = 0xFFFF.
  - Also `a` = 7, `b` = 0xFFFE: required `quotient` = 0xFFFD, `remainder` = 1.
- **Boundaries.**
  - `a` = 0x1234, `b` = 0: required `ready` one edge after issue, `quotient` = 0xFFFF, `remainder` = 0x1234, `div_zero` = 1.
  - Signed 0x8000 / 0xFFFF: required `quotient` = 0x8000, `remainder` = 0, `div_zero` = 0.
- **Flush mid-operation.**
  - Issue 1000 / 3, then assert `flush` at edge 5.
  - Required: `busy` = 0 after edge 6, no `ready` pulse, previous results retained.
  - Then issue 9 / 4: required `quotient` = 2, `remainder` = 1 at the normal latency.
- **Start handling.**
  - Hold `start` high with new operands throughout CALC: required to be ignored.
  - Assert `start` in the DONE cycle: required to be accepted, with the second result 17 edges later.
  - Assert `start` and `flush` together: required not to be accepted.
- **Reset and width variants.**
  - Assert `rst` mid-CALC: required all outputs 0 after that edge.
  - With DATA_W = 8, SIGNED_EN = 0, compute 200 / 9: required `quotient` = 22, `remainder` = 2, latency 9, and `signed_mode` = 1 is ignored.
